// File: rtl/sdram_pattern_tester_if.sv
// Command-FIFO and read-return bus between the pattern tester (master) and the
// SDRAM controller (slave).
interface sdram_pattern_tester_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MASK_W = DATA_W / 8
);
  logic              cmd_write;
  logic              cmd_full;
  logic              cmd_is_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [MASK_W-1:0] cmd_mask;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_write, cmd_is_write, cmd_addr, cmd_mask, cmd_wdata,
    input  cmd_full, rd_valid, rd_addr, rd_data
  );

  modport slave (
    input  cmd_write, cmd_is_write, cmd_addr, cmd_mask, cmd_wdata,
    output cmd_full, rd_valid, rd_addr, rd_data
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// Self-running SDRAM test engine: writes a pattern over an address range, reads it back,
// checks every returned word and reports error count, first failure and read timeout.
module sdram_pattern_tester #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MASK_W  = DATA_W / 8,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned ERR_W   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [DATA_W-1:0]     first_err_exp,
  output logic [DATA_W-1:0]     first_err_got,
  sdram_pattern_tester_if.master bus
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, base_q, base_d, last_q, last_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [1:0]        mode_q, mode_d;
  logic [OutW-1:0]   out_q, out_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

  logic              active, issue_ok, fire, rd_fire, rv, mismatch, to_hit;
  logic [DATA_W-1:0] exp_data;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [1:0]        m,
                                                input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] a_ext;
    a_ext = DATA_W'(a);
    unique case (m)
      2'd0:    pattern = a_ext ^ s;
      2'd1:    pattern = ~(a_ext ^ s);
      2'd2:    pattern = s;
      default: pattern = (a[0] ? {MASK_W{8'h55}} : {MASK_W{8'hAA}}) ^ s;
    endcase
  endfunction

  always_comb begin
    active   = (state_q == StRead) || (state_q == StDrain);
    issue_ok = (state_q == StWrite) || ((state_q == StRead) && (out_q < OutW'(MAX_OUT)));
    fire     = issue_ok && !bus.cmd_full;
    rd_fire  = fire && (state_q == StRead);
    // Late or stray returns (no read outstanding, or outside the read phase) are dropped.
    rv       = bus.rd_valid && active && (out_q != '0);
    exp_data = pattern(bus.rd_addr, mode_q, seed_q);
    mismatch = rv && (bus.rd_data != exp_data);
    to_hit   = active && (out_q != '0) && !rv && (to_cnt_q == ToW'(TIMEOUT - 1));

    state_d   = state_q;
    ptr_d     = ptr_q;
    base_d    = base_q;
    last_d    = last_q;
    seed_d    = seed_q;
    mode_d    = mode_q;
    out_d     = out_q + OutW'(rd_fire) - OutW'(rv);
    to_cnt_d  = (active && (out_q != '0) && !rv) ? to_cnt_q + 1'b1 : '0;
    timeout_d = timeout_q;
    err_d     = err_q;
    fe_addr_d = fe_addr_q;
    fe_exp_d  = fe_exp_q;
    fe_got_d  = fe_got_q;

    if (mismatch) begin
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fe_addr_d = bus.rd_addr;
        fe_exp_d  = exp_data;
        fe_got_d  = bus.rd_data;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          base_d    = base_addr;
          last_d    = last_addr;
          seed_d    = seed;
          mode_d    = mode;
          ptr_d     = base_addr;
          out_d     = '0;
          to_cnt_d  = '0;
          timeout_d = 1'b0;
          err_d     = '0;
          fe_addr_d = '0;
          fe_exp_d  = '0;
          fe_got_d  = '0;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (fire) begin
          if (ptr_q == last_q) begin
            ptr_d   = base_q;
            state_d = StRead;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      StRead: begin
        if (fire) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == last_q) state_d = StDrain;
        end
        if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDrain: begin
        if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (out_q == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      base_q    <= '0;
      last_q    <= '0;
      seed_q    <= '0;
      mode_q    <= '0;
      out_q     <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      base_q    <= base_d;
      last_q    <= last_d;
      seed_q    <= seed_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      fe_addr_q <= fe_addr_d;
      fe_exp_q  <= fe_exp_d;
      fe_got_q  <= fe_got_d;
    end
  end

  always_comb begin
    busy             = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    done             = (state_q == StDone);
    pass             = (state_q == StDone) && (err_q == '0) && !timeout_q;
    timeout          = timeout_q;
    err_count        = err_q;
    first_err_addr   = fe_addr_q;
    first_err_exp    = fe_exp_q;
    first_err_got    = fe_got_q;
    bus.cmd_write    = fire;
    bus.cmd_is_write = (state_q == StWrite);
    bus.cmd_addr     = ptr_q;
    bus.cmd_mask     = '1;
    bus.cmd_wdata    = pattern(ptr_q, mode_q, seed_q);
  end

endmodule
